// File: rtl/bfm_ahbl_slave_if.sv
// rtl/bfm_ahbl_slave_if.sv - AHB-Lite bus bundle between a master BFM and the responder model
interface bfm_ahbl_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [2:0]  HBURST;
   logic        HMASTLOCK;
   logic [3:0]  HPROT;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HMASTLOCK, HPROT, HREADY, HWDATA,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HMASTLOCK, HPROT, HREADY, HWDATA,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/bfm_ahbl_slave.sv
// rtl/bfm_ahbl_slave.sv - AHB-Lite responder model with wait states, error window and byte-lane RAM
module bfm_ahbl_slave #(
   parameter int          AWIDTH      = 10,
   parameter int          WAIT_STATES = 0,
   parameter int          ERR_EN      = 0,
   parameter logic [31:0] ERR_BASE    = 32'hFFFF_F000,
   parameter logic [31:0] ERR_MASK    = 32'hFFFF_F000
) (
   input logic             HCLK,
   input logic             HRESETN,
   bfm_ahbl_slave_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t              state;
   logic                ready_q;
   logic                resp_q;
   logic [3:0]          wait_cnt;
   logic [AWIDTH+1:0]   addr_q;
   logic                write_q;
   logic [1:0]          size_q;
   logic [3:0]          be;
   logic                accept;
   logic                win_hit;
   logic                bad;
   logic [AWIDTH-1:0]   idx;
   logic [31:0]         mem [2**AWIDTH];

   logic unused_ok;
   assign unused_ok = &{1'b0, bus.HBURST, bus.HMASTLOCK, bus.HPROT};

   assign accept  = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
   assign win_hit = (ERR_EN != 0) && ((bus.HADDR & ERR_MASK) == ERR_BASE);
   assign bad     = win_hit
                 || (bus.HSIZE > 3'd2)
                 || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
                 || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
   assign idx     = addr_q[AWIDTH+1:2];

   // Only legal, aligned sizes ever reach DATA, so the lane decode can assume alignment.
   always_comb begin
      be = 4'b0000;
      case (size_q)
         2'd0:    be[addr_q[1:0]] = 1'b1;
         2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETN) begin
         state    <= ST_IDLE;
         ready_q  <= 1'b1;
         resp_q   <= 1'b0;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state   <= ST_DATA;
                  ready_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state   <= ST_ERR2;
               ready_q <= 1'b1;
               resp_q  <= 1'b1;
            end
            default: begin
               if (accept) begin
                  addr_q  <= bus.HADDR[AWIDTH+1:0];
                  write_q <= bus.HWRITE;
                  size_q  <= bus.HSIZE[1:0];
                  if (bad) begin
                     state   <= ST_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= 1'b1;
                  end else if (WAIT_STATES > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= 4'(WAIT_STATES - 1);
                     ready_q  <= 1'b0;
                     resp_q   <= 1'b0;
                  end else begin
                     state   <= ST_DATA;
                     ready_q <= 1'b1;
                     resp_q  <= 1'b0;
                  end
               end else begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   // A reset landing on the commit edge drops the write.
   always_ff @(posedge HCLK) begin
      if (HRESETN && (state == ST_DATA) && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
            end
         end
      end
   end

   assign bus.HREADYOUT = ready_q;
   assign bus.HRESP     = resp_q;
   assign bus.HRDATA    = ((state == ST_DATA) && !write_q) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_bfm_ahbl_slave.sv
// tb/tb_bfm_ahbl_slave.sv - self-checking bench for bfm_ahbl_slave against a transaction-level model
module tb_bfm_ahbl_slave;
   localparam int AW = 10;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } beat_t;

   logic        HCLK = 1'b0;
   logic        HRESETN;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic        hready;
   logic        sresp;
   logic [31:0] srdata;
   int          sel_id;
   logic [2:0]  rdy;
   logic [2:0]  rsp;
   logic [31:0] rdat [3];

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem_m [3][1024];
   beat_t       bq [$];

   always #5 HCLK = ~HCLK;

   for (genvar k = 0; k < 3; k++) begin : g_slv
      bfm_ahbl_slave_if bus ();
      assign bus.HSEL      = hsel && (sel_id == k);
      assign bus.HADDR     = haddr;
      assign bus.HWRITE    = hwrite;
      assign bus.HSIZE     = hsize;
      assign bus.HTRANS    = htrans;
      assign bus.HBURST    = 3'd0;
      assign bus.HMASTLOCK = 1'b0;
      assign bus.HPROT     = 4'd0;
      assign bus.HREADY    = hready;
      assign bus.HWDATA    = hwdata;
      assign rdy[k]        = bus.HREADYOUT;
      assign rsp[k]        = bus.HRESP;
      assign rdat[k]       = bus.HRDATA;

      bfm_ahbl_slave #(
         .AWIDTH      (AW),
         .WAIT_STATES (k == 0 ? 0 : (k == 1 ? 2 : 3)),
         .ERR_EN      (k == 0 ? 1 : 0)
      ) u_dut (
         .HCLK    (HCLK),
         .HRESETN (HRESETN),
         .bus     (bus)
      );
   end

   always_comb begin
      hready = 1'b1;
      sresp  = 1'b0;
      srdata = 32'h0;
      case (sel_id)
         0: begin hready = rdy[0]; sresp = rsp[0]; srdata = rdat[0]; end
         1: begin hready = rdy[1]; sresp = rsp[1]; srdata = rdat[1]; end
         2: begin hready = rdy[2]; sresp = rsp[2]; srdata = rdat[2]; end
         default: ;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int ws_of(input int s);
      return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
   endfunction

   function automatic logic is_bad(input int s, input beat_t b);
      return ((s == 0) && ((b.addr & 32'hFFFF_F000) == 32'hFFFF_F000))
          || (b.size > 3'd2)
          || ((b.size == 3'd1) && b.addr[0])
          || ((b.size == 3'd2) && (b.addr[1:0] != 2'b00));
   endfunction

   task automatic model_write(input int s, input beat_t b);
      int nb;
      int lane0;
      int w;
      nb    = 1 << b.size;
      lane0 = int'(b.addr[1:0]);
      w     = int'(b.addr[11:2]);
      for (int k = 0; k < nb; k++) begin
         mem_m[s][w][8*(lane0+k) +: 8] = b.wdata[8*(lane0+k) +: 8];
      end
   endtask

   task automatic push(input logic s, input logic [1:0] t, input logic w, input logic [2:0] z,
                       input logic [31:0] a, input logic [31:0] d);
      beat_t b;
      b.sel = s; b.trans = t; b.wr = w; b.size = z; b.addr = a; b.wdata = d;
      bq.push_back(b);
   endtask

   // Plays the queued beats as a pipelined master; called and returns at posedge+1.
   task automatic run_beats(output int dcycles);
      int   ai;
      int   di;
      int   waits;
      int   guard;
      logic r;
      logic e;
      logic b_bad;
      logic [31:0] d;
      logic [31:0] exp_d;
      ai = 0; di = -1; waits = 0; dcycles = 0; guard = 0;
      while ((ai < bq.size() || di >= 0) && guard < 400) begin
         guard++;
         if (ai < bq.size()) begin
            hsel = bq[ai].sel; htrans = bq[ai].trans; hwrite = bq[ai].wr;
            hsize = bq[ai].size; haddr = bq[ai].addr;
         end else begin
            hsel = 1'b0; htrans = 2'd0;
         end
         if (di >= 0) hwdata = bq[di].wdata;
         #1;
         r = hready; e = sresp; d = srdata;
         if (di >= 0) begin
            dcycles++;
            b_bad = is_bad(sel_id, bq[di]);
            check_eq("resp", 32'(e), 32'(b_bad));
            if (!r) begin
               waits++;
               check_eq("rdata_in_wait", d, 32'h0);
            end else begin
               check_eq("wait_cycles", waits, b_bad ? 1 : ws_of(sel_id));
               exp_d = (!bq[di].wr && !b_bad) ? mem_m[sel_id][int'(bq[di].addr[11:2])] : 32'h0;
               check_eq("rdata", d, exp_d);
               if (bq[di].wr && !b_bad) model_write(sel_id, bq[di]);
               waits = 0;
            end
         end else begin
            check_eq("idle_ready", 32'(r), 32'h1);
            check_eq("idle_resp", 32'(e), 32'h0);
            check_eq("idle_rdata", d, 32'h0);
         end
         if (r) begin
            if (ai < bq.size()) begin
               di = (bq[ai].sel && bq[ai].trans[1]) ? ai : -1;
               ai++;
            end else begin
               di = -1;
            end
         end
         @(posedge HCLK); #1;
      end
      if (guard >= 400) check_eq("beat_timeout", 32'h1, 32'h0);
      hsel = 1'b0; htrans = 2'd0;
      bq.delete();
   endtask

   initial begin
      int dc;
      beat_t rb;
      HRESETN = 1'b0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
      htrans = 2'd0; hwdata = 32'h0; sel_id = 0;
      repeat (3) @(posedge HCLK);
      #1 HRESETN = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_eq("reset_ready", 32'(rdy[k]), 32'h1);
         check_eq("reset_resp", 32'(rsp[k]), 32'h0);
         check_eq("reset_rdata", rdat[k], 32'h0);
      end

      for (int s = 0; s < 3; s++) begin
         sel_id = s;
         for (int w = 0; w < 20; w++) push(1, 2'd2, 1, 3'd2, 32'(4*w), $urandom);
         run_beats(dc);
      end

      // zero-wait slave with the error window
      sel_id = 0;
      push(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF);
      push(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
      run_beats(dc);
      check_eq("b2b_cycles", dc, 2);
      push(1, 2'd2, 1, 3'd2, 32'h10, 32'h0);
      push(1, 2'd3, 1, 3'd2, 32'h14, 32'h0);
      push(1, 2'd2, 1, 3'd0, 32'h13, 32'h1111_1111);
      push(1, 2'd2, 1, 3'd1, 32'h14, 32'hAAAA_2233);
      push(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
      push(1, 2'd3, 0, 3'd2, 32'h14, 32'h0);
      run_beats(dc);
      push(1, 2'd2, 1, 3'd2, 32'hFFFF_F004, 32'h1);
      push(1, 2'd2, 1, 3'd2, 32'h0000_0002, 32'hAAAA);
      push(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
      push(1, 2'd2, 0, 3'd2, 32'h0, 32'h0);
      push(1, 2'd2, 1, 3'd2, 32'h0000_1008, 32'h5A5A_5A5A);
      push(1, 2'd2, 0, 3'd2, 32'h8, 32'h0);
      run_beats(dc);
      push(0, 2'd2, 1, 3'd2, 32'h10, 32'h1234);
      push(1, 2'd0, 1, 3'd2, 32'h10, 32'h5678);
      push(1, 2'd1, 1, 3'd2, 32'h10, 32'h9ABC);
      push(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
      run_beats(dc);
      check_eq("idle_beats_cycles", dc, 1);

      // two-wait slave: single read then a 4-beat burst
      sel_id = 1;
      push(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
      run_beats(dc);
      check_eq("ws2_read_cycles", dc, 3);
      push(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
      push(1, 2'd3, 0, 3'd2, 32'h24, 32'h0);
      push(1, 2'd3, 0, 3'd2, 32'h28, 32'h0);
      push(1, 2'd3, 0, 3'd2, 32'h2C, 32'h0);
      run_beats(dc);
      check_eq("burst_cycles", dc, 12);

      // three-wait slave: reset in the middle of a write's wait states
      sel_id = 2;
      push(1, 2'd2, 1, 3'd2, 32'h40, 32'h1234_5678);
      run_beats(dc);
      hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
      @(posedge HCLK); #1;
      hsel = 1'b0; htrans = 2'd0; hwdata = 32'hCAFE_F00D;
      #1 check_eq("mid_wait_ready", 32'(hready), 32'h0);
      @(posedge HCLK); #1;
      HRESETN = 1'b0;
      @(posedge HCLK); @(posedge HCLK); #1;
      HRESETN = 1'b1;
      check_eq("post_reset_ready", 32'(hready), 32'h1);
      check_eq("post_reset_resp", 32'(sresp), 32'h0);
      check_eq("post_reset_rdata", srdata, 32'h0);
      push(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
      run_beats(dc);

      for (int s = 0; s < 3; s++) begin
         sel_id = s;
         for (int i = 0; i < 40; i++) begin
            int t;
            t = int'($urandom_range(0, 9));
            rb.sel   = ($urandom_range(0, 9) != 0);
            rb.trans = (t == 0) ? 2'd0 : ((t == 1) ? 2'd1 : ((t < 6) ? 2'd2 : 2'd3));
            rb.wr    = 1'($urandom_range(0, 1));
            rb.size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            rb.addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 63)))
                     : (32'($urandom_range(0, 79)) | (32'($urandom_range(0, 3)) << 12));
            rb.wdata = $urandom;
            bq.push_back(rb);
         end
         run_beats(dc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
